// File: rtl/fft_fixed_pkg.sv
// Fixed-point helpers shared by the FFT datapath and its output interface.
//   N_DEFAULT   : default word width for sign-magnitude and two's complement
//   sm2tc       : sign-magnitude -> two's complement (negative zero -> 0)
//   is_neg_zero : true for the sign-magnitude pattern 1000...0
package fft_fixed_pkg;

  localparam int N_DEFAULT = 8;

  function automatic logic [N_DEFAULT-1:0] sm2tc(input logic [N_DEFAULT-1:0] x);
    logic [N_DEFAULT-1:0] mag;
    mag = {1'b0, x[N_DEFAULT-2:0]};
    // Negating a zero magnitude yields zero, so negative zero needs no special case.
    return x[N_DEFAULT-1] ? -mag : mag;
  endfunction

  function automatic logic is_neg_zero(input logic [N_DEFAULT-1:0] x);
    return x[N_DEFAULT-1] && (x[N_DEFAULT-2:0] == '0);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Registered valid/ready slice with a one-entry skid register.
//   clk, rst_n              : clock, async active-low reset
//   in_valid_i / in_ready_o : upstream handshake (in_ready_o is a register)
//   in_data_i               : upstream payload, W bits
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o              : downstream payload, held while stalled
module skid_buffer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         in_fire, out_free;

  // Ready depends only on state, so there is no combinational path upstream.
  assign in_ready_o  = !skid_valid_q;
  assign in_fire     = in_valid_i && !skid_valid_q;
  assign out_free    = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      // Skid full implies output full; drain the skid on the next transfer.
      if (out_ready_i) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      if (out_free) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        skid_data_d  = in_data_i;
        skid_valid_d = 1'b1;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  // NOTE: skid payload is qualified by skid_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/sm_to_tc_stream.sv
// Streaming sign-magnitude to two's complement converter for the FFT output.
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready       : input handshake; s_re/s_im sign-magnitude
//   m_valid/m_ready       : output handshake; m_re/m_im two's complement
//   m_last                : tags sample FFT_POINTS-1 of each frame
//   nz_seen               : sticky flag, a negative zero was accepted
//   clr                   : sync clear of frame counter and nz_seen
// N must match fft_fixed_pkg::N_DEFAULT, since the conversion helpers are
// shared with the FFT adders.
module sm_to_tc_stream
  import fft_fixed_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int FFT_POINTS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] s_re,
  input  logic [N-1:0] s_im,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_re,
  output logic [N-1:0] m_im,
  output logic         m_last,
  output logic         nz_seen,
  input  logic         clr
);

  localparam int CW = $clog2(FFT_POINTS);
  localparam int W  = 2 * N + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          nz_q, nz_d;
  logic          in_fire, in_last;
  logic [W-1:0]  in_payload, out_payload;

  // The last tag is attached on acceptance and travels with the sample, so a
  // clr never retags beats already sitting in the skid or output register.
  assign in_fire    = s_valid && s_ready;
  assign in_last    = (cnt_q == CW'(FFT_POINTS - 1));
  assign in_payload = {in_last, sm2tc(s_re), sm2tc(s_im)};

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire) cnt_d = in_last ? '0 : cnt_q + 1'b1;
    if (clr) cnt_d = '0;

    // Set has priority over clear in the same cycle.
    nz_d = clr ? 1'b0 : nz_q;
    if (in_fire && (is_neg_zero(s_re) || is_neg_zero(s_im))) nz_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      nz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nz_q  <= nz_d;
    end
  end

  skid_buffer #(.W(W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (s_valid),
    .in_ready_o (s_ready),
    .in_data_i  (in_payload),
    .out_valid_o(m_valid),
    .out_ready_i(m_ready),
    .out_data_o (out_payload)
  );

  assign {m_last, m_re, m_im} = out_payload;
  assign nz_seen = nz_q;

endmodule

// File: tb/tb_sm_to_tc_stream.sv
module tb_sm_to_tc_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, m_valid, m_ready, m_last, nz_seen, clr;
  logic [7:0] s_re, s_im, m_re, m_im;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         in_cnt, out_cnt;
  logic       stalled;
  logic [7:0] hold_re, hold_im;
  logic       hold_last;

  sm_to_tc_stream #(.N(8), .FFT_POINTS(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_re   (s_re),
    .s_im   (s_im),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_re   (m_re),
    .m_im   (m_im),
    .m_last (m_last),
    .nz_seen(nz_seen),
    .clr    (clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference conversion written from the arithmetic definition.
  function automatic logic [7:0] conv(input logic [7:0] x);
    int v;
    v = int'(x[6:0]);
    if (x[7]) v = -v;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Back-to-back beats with m_ready=1; beat k carries re=k, im=-k (sign-mag).
  task automatic burst(input int n, input string tag);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        check({tag, "_valid"}, m_valid, 1);
        check({tag, "_re"}, m_re, conv(8'(i - 1)));
        check({tag, "_im"}, m_im, conv(8'h80 | 8'(i - 1)));
        check({tag, "_last"}, m_last, ((i - 1) % 8) == 7);
      end
      if (i < n) begin
        s_valid = 1'b1;
        s_re    = 8'(i);
        s_im    = 8'h80 | 8'(i);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b1; clr = 1'b0;
    s_re = 8'h00; s_im = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_re", m_re, 0);
    check("rst_m_im", m_im, 0);
    check("rst_m_last", m_last, 0);
    check("rst_nz", nz_seen, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion, one-cycle latency
    s_valid = 1'b1; s_re = 8'h85; s_im = 8'h05;
    @(negedge clk);
    check("b1_valid", m_valid, 1);
    check("b1_re", m_re, 8'hFB);
    check("b1_im", m_im, 8'h05);
    check("b1_nz", nz_seen, 0);
    s_re = 8'h80; s_im = 8'hFF;
    @(negedge clk);
    check("nz_re", m_re, 8'h00);
    check("nz_im", m_im, 8'h81);
    check("nz_flag", nz_seen, 1);
    s_valid = 1'b0;
    @(negedge clk);
    check("drain_valid", m_valid, 0);
    check("nz_sticky", nz_seen, 1);
    clr = 1'b1;
    @(negedge clk);
    check("clr_nz", nz_seen, 0);

    // clr and negative zero in the same cycle: set wins
    s_valid = 1'b1; s_re = 8'h7F; s_im = 8'h80; clr = 1'b1;
    @(negedge clk);
    check("setwin_nz", nz_seen, 1);
    check("pos_max_re", m_re, 8'h7F);
    check("negz_im", m_im, 8'h00);
    s_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr2_nz", nz_seen, 0);

    // 16 back-to-back beats: m_last on beats 8 and 16
    burst(16, "b2b");
    check("b2b_empty", m_valid, 0);

    // Stall of 3 cycles mid-stream
    s_valid = 1'b1; s_re = 8'h83; s_im = 8'h10; m_ready = 1'b1;
    @(negedge clk);
    check("st_b0_re", m_re, 8'hFD);
    s_re = 8'h01; s_im = 8'h8A; m_ready = 1'b0;
    @(negedge clk);
    check("st_ready0", s_ready, 0);
    check("st_hold_re1", m_re, 8'hFD);
    s_re = 8'h7F; s_im = 8'hFF;
    @(negedge clk);
    check("st_ready1", s_ready, 0);
    check("st_hold_re2", m_re, 8'hFD);
    check("st_hold_im2", m_im, 8'h10);
    @(negedge clk);
    check("st_hold_valid", m_valid, 1);
    check("st_hold_re3", m_re, 8'hFD);
    m_ready = 1'b1;
    @(negedge clk);
    check("st_b1_re", m_re, 8'h01);
    check("st_b1_im", m_im, 8'hF6);
    check("st_ready_back", s_ready, 1);
    @(negedge clk);
    check("st_b2_re", m_re, 8'h7F);
    check("st_b2_im", m_im, 8'h81);
    check("st_b2_last", m_last, 0);
    s_valid = 1'b0;
    @(negedge clk);
    check("st_empty", m_valid, 0);

    // Random handshakes against a scoreboard
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_cnt = 0; out_cnt = 0; stalled = 1'b0;
    for (int cyc = 0; cyc < 4000 && out_cnt < 300; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        check("rnd_hold_valid", m_valid, 1);
        check("rnd_hold_re", m_re, hold_re);
        check("rnd_hold_im", m_im, hold_im);
        check("rnd_hold_last", m_last, hold_last);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = (in_cnt < 300) && ($urandom_range(0, 3) != 0);
      s_re    = 8'($urandom);
      s_im    = 8'($urandom);
      #1;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("rnd_unexpected_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rnd_re", m_re, e.re);
          check("rnd_im", m_im, e.im);
          check("rnd_last", m_last, e.last);
        end
        out_cnt++;
      end
      if (s_valid && s_ready) begin
        e.re = conv(s_re); e.im = conv(s_im); e.last = ((in_cnt % 8) == 7);
        sb.push_back(e);
        in_cnt++;
      end
      stalled   = m_valid && !m_ready;
      hold_re   = m_re;
      hold_im   = m_im;
      hold_last = m_last;
    end
    check("rnd_out_count", out_cnt, 300);
    check("rnd_sb_empty", sb.size(), 0);
    s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);

    // Reset mid-stream with the skid full
    s_valid = 1'b1; s_re = 8'h11; s_im = 8'h22; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rs_skid_full", s_ready, 0);
    check("rs_valid_pre", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rs_m_valid", m_valid, 0);
    check("rs_s_ready", s_ready, 1);
    check("rs_m_re", m_re, 0);
    check("rs_m_last", m_last, 0);
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    check("rs_idle", m_valid, 0);
    burst(9, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
